// File: rtl/calc_pkg.sv
// Shared key codes, operator and entry-state encodings for the calculator entry path.
package calc_pkg;

   localparam logic [4:0] KEY_ADD  = 5'h10;
   localparam logic [4:0] KEY_MUL  = 5'h11;
   localparam logic [4:0] KEY_AND  = 5'h12;
   localparam logic [4:0] KEY_EXE  = 5'h13;
   localparam logic [4:0] KEY_SUB  = 5'h14;
   localparam logic [4:0] KEY_OR   = 5'h15;
   localparam logic [4:0] KEY_CE   = 5'h16;
   localparam logic [4:0] KEY_CLR  = 5'h17;
   localparam logic [4:0] KEY_NONE = 5'h1F;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_MUL  = 3'd3,
      OP_AND  = 3'd4,
      OP_OR   = 3'd5
   } op_t;

   typedef enum logic [1:0] {
      S_A   = 2'd0,
      S_OP  = 2'd1,
      S_B   = 2'd2,
      S_RES = 2'd3
   } entry_state_t;

   function automatic logic key_is_op(input logic [4:0] k);
      return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL) ||
             (k == KEY_AND) || (k == KEY_OR);
   endfunction

   function automatic op_t key_to_op(input logic [4:0] k);
      op_t o;
      case (k)
         KEY_ADD: o = OP_ADD;
         KEY_SUB: o = OP_SUB;
         KEY_MUL: o = OP_MUL;
         KEY_AND: o = OP_AND;
         KEY_OR:  o = OP_OR;
         default: o = OP_NONE;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational W-bit calculator ALU; results wrap modulo 2^W and ovf flags the wrap
// (or, in decimal mode, a result beyond the largest enterable decimal value).
module calc_alu
   import calc_pkg::*;
#(
   parameter int          W       = 16,
   parameter int unsigned DEC_MAX = 9999
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  op_t          op,
   input  logic         dec_mode,
   output logic [W-1:0] result,
   output logic         ovf
);

   localparam logic [W-1:0] DEC_LIM = DEC_MAX[W-1:0];

   logic [W:0]     sum;
   logic [2*W-1:0] prod;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

   always_comb begin
      result = a;
      ovf    = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[W-1:0];
            ovf    = sum[W];
         end
         OP_SUB: begin
            result = a - b;
            ovf    = (b > a);
         end
         OP_MUL: begin
            result = prod[W-1:0];
            ovf    = |prod[2*W-1:W];
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         default: begin
            result = a;
            ovf    = 1'b0;
         end
      endcase
      // Decimal limit applies to whatever value ends up on the display.
      if (dec_mode && (result > DEC_LIM)) ovf = 1'b1;
   end

endmodule

// File: rtl/calc_entry_fsm.sv
// Key-entry FSM: assembles A, operator and B from select pulses, evaluates on EXE or
// on a chained operator, and chooses the value to display for the current state.
module calc_entry_fsm
   import calc_pkg::*;
#(
   parameter int W          = 16,
   parameter int HEX_DIGITS = 4,
   parameter int DEC_DIGITS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         select,
   input  logic [4:0]   val,
   input  logic         dec_mode,
   output logic [W-1:0] display_value,
   output logic [2:0]   op_code,
   output logic [1:0]   state,
   output logic         overflow,
   output logic         result_valid
);

   localparam int unsigned DEC_MAX    = (10 ** DEC_DIGITS) - 1;
   localparam int          MAX_DIGITS = (HEX_DIGITS > DEC_DIGITS) ? HEX_DIGITS : DEC_DIGITS;
   localparam int          CW         = $clog2(MAX_DIGITS + 1);

   entry_state_t  state_q, state_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
   logic [CW-1:0] cnt_q, cnt_d;
   op_t           op_q, op_d;
   logic          ovf_q, ovf_d;
   logic          rv_q, rv_d;

   logic [W-1:0]  alu_res;
   logic          alu_ovf;
   logic [3:0]    digit;
   logic [W-1:0]  digit_w;
   logic          digit_ok;
   logic          digit_room;
   logic [CW-1:0] digit_limit;

   calc_alu #(.W(W), .DEC_MAX(DEC_MAX)) u_alu (
      .a        (a_q),
      .b        (b_q),
      .op       (op_q),
      .dec_mode (dec_mode),
      .result   (alu_res),
      .ovf      (alu_ovf)
   );

   function automatic logic [W-1:0] append_digit(input logic [W-1:0] operand,
                                                 input logic [W-1:0] d,
                                                 input logic         dec);
      if (dec) return (operand * W'(10)) + d;
      else     return {operand[W-5:0], d[3:0]};
   endfunction

   assign digit       = val[3:0];
   assign digit_w     = {{(W-4){1'b0}}, digit};
   assign digit_ok    = !val[4] && !(dec_mode && (digit > 4'd9));
   assign digit_limit = dec_mode ? CW'(DEC_DIGITS) : CW'(HEX_DIGITS);
   assign digit_room  = (cnt_q < digit_limit);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         op_q    <= OP_NONE;
         ovf_q   <= 1'b0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         ovf_q   <= ovf_d;
         rv_q    <= rv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      ovf_d   = ovf_q;
      rv_d    = 1'b0;

      if (select) begin
         // CE on a shown result is a full clear, same as CLR.
         if ((val == KEY_CLR) || ((val == KEY_CE) && (state_q == S_RES))) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            res_d   = '0;
            cnt_d   = '0;
            op_d    = OP_NONE;
            ovf_d   = 1'b0;
         end else begin
            case (state_q)
               S_A: begin
                  if (digit_ok && digit_room) begin
                     a_d   = append_digit(a_q, digit_w, dec_mode);
                     cnt_d = cnt_q + CW'(1);
                  end else if (key_is_op(val)) begin
                     op_d    = key_to_op(val);
                     state_d = S_OP;
                  end else if (val == KEY_CE) begin
                     a_d   = '0;
                     cnt_d = '0;
                  end
               end
               S_OP: begin
                  if (digit_ok) begin
                     b_d     = digit_w;
                     cnt_d   = CW'(1);
                     state_d = S_B;
                  end else if (key_is_op(val)) begin
                     op_d = key_to_op(val);
                  end
               end
               S_B: begin
                  if (digit_ok && digit_room) begin
                     b_d   = append_digit(b_q, digit_w, dec_mode);
                     cnt_d = cnt_q + CW'(1);
                  end else if ((val == KEY_EXE) || key_is_op(val)) begin
                     res_d   = alu_res;
                     a_d     = alu_res;
                     ovf_d   = alu_ovf;
                     rv_d    = 1'b1;
                     state_d = S_RES;
                     if (key_is_op(val)) begin
                        op_d    = key_to_op(val);
                        state_d = S_OP;
                     end
                  end else if (val == KEY_CE) begin
                     b_d     = '0;
                     cnt_d   = '0;
                     state_d = S_OP;
                  end
               end
               S_RES: begin
                  if (digit_ok) begin
                     a_d     = digit_w;
                     cnt_d   = CW'(1);
                     ovf_d   = 1'b0;
                     state_d = S_A;
                  end else if (key_is_op(val)) begin
                     op_d    = key_to_op(val);
                     state_d = S_OP;
                  end
               end
               default: state_d = S_A;
            endcase
         end
      end
   end

   always_comb begin
      case (state_q)
         S_B:     display_value = b_q;
         S_RES:   display_value = res_q;
         default: display_value = a_q;
      endcase
   end

   assign op_code      = op_q;
   assign state        = state_q;
   assign overflow     = ovf_q;
   assign result_valid = rv_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Bench for calc_entry_fsm: directed scenarios plus random key streams checked
// against an arithmetic reference model of the calculator.
module tb_calc_entry_fsm;
   import calc_pkg::*;

   logic        clk;
   logic        rst;
   logic        select;
   logic [4:0]  val;
   logic        dec_mode;
   logic [15:0] display_value;
   logic [2:0]  op_code;
   logic [1:0]  state;
   logic        overflow;
   logic        result_valid;

   int n_pass;
   int n_total;

   // reference model
   int unsigned  m_a, m_b, m_res, m_cnt;
   op_t          m_op;
   entry_state_t m_st;
   logic         m_ovf, m_rv;

   calc_entry_fsm #(.W(16), .HEX_DIGITS(4), .DEC_DIGITS(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .select        (select),
      .val           (val),
      .dec_mode      (dec_mode),
      .display_value (display_value),
      .op_code       (op_code),
      .state         (state),
      .overflow      (overflow),
      .result_valid  (result_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_a = 0; m_b = 0; m_res = 0; m_cnt = 0;
      m_op = OP_NONE; m_st = S_A; m_ovf = 1'b0; m_rv = 1'b0;
   endtask

   function automatic int unsigned m_disp();
      if (m_st == S_B)   return m_b;
      if (m_st == S_RES) return m_res;
      return m_a;
   endfunction

   function automatic int unsigned m_append(input int unsigned x, input int unsigned d);
      if (dec_mode) return (x * 10 + d) % 65536;
      return (x * 16 + d) % 65536;
   endfunction

   task automatic model_compute();
      longint unsigned x;
      logic o;
      o = 1'b0;
      x = m_a;
      case (m_op)
         OP_ADD: begin x = longint'(m_a) + m_b; o = (x > 65535); end
         OP_SUB: begin x = (65536 + longint'(m_a) - m_b) % 65536; o = (m_b > m_a); end
         OP_MUL: begin x = longint'(m_a) * m_b; o = (x > 65535); end
         OP_AND: x = m_a & m_b;
         OP_OR:  x = m_a | m_b;
         default: x = m_a;
      endcase
      x = x % 65536;
      if (dec_mode && x > 9999) o = 1'b1;
      m_res = int'(x); m_a = int'(x); m_ovf = o; m_rv = 1'b1;
   endtask

   task automatic model_apply(input logic [4:0] k);
      bit is_dig, is_op;
      int unsigned d;
      m_rv   = 1'b0;
      d      = k[3:0];
      is_dig = (k < 16) && !(dec_mode && d > 9);
      is_op  = (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL) || (k == KEY_AND) || (k == KEY_OR);
      if (k == KEY_CLR || (k == KEY_CE && m_st == S_RES)) begin
         model_reset();
         return;
      end
      case (m_st)
         S_A: begin
            if (is_dig) begin
               if (m_cnt < 4) begin m_a = m_append(m_a, d); m_cnt++; end
            end else if (is_op) begin m_op = key_to_op(k); m_st = S_OP; end
            else if (k == KEY_CE) begin m_a = 0; m_cnt = 0; end
         end
         S_OP: begin
            if (is_dig) begin m_b = d; m_cnt = 1; m_st = S_B; end
            else if (is_op) m_op = key_to_op(k);
         end
         S_B: begin
            if (is_dig) begin
               if (m_cnt < 4) begin m_b = m_append(m_b, d); m_cnt++; end
            end else if (k == KEY_EXE) begin model_compute(); m_st = S_RES; end
            else if (is_op) begin model_compute(); m_op = key_to_op(k); m_st = S_OP; end
            else if (k == KEY_CE) begin m_b = 0; m_cnt = 0; m_st = S_OP; end
         end
         default: begin
            if (is_dig) begin m_a = d; m_cnt = 1; m_ovf = 1'b0; m_st = S_A; end
            else if (is_op) begin m_op = key_to_op(k); m_st = S_OP; end
         end
      endcase
   endtask

   // one select pulse; outputs are sampled 1 time unit after the capturing edge
   task automatic press(input logic [4:0] k);
      @(negedge clk);
      val = k;
      select = 1'b1;
      @(posedge clk);
      #1;
      select = 1'b0;
      val = KEY_NONE;
      model_apply(k);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      m_rv = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; select = 1'b0; val = KEY_NONE; dec_mode = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (display_value !== 16'h0 || state !== S_A || op_code !== OP_NONE || overflow !== 1'b0 || result_valid !== 1'b0)
         $display("FAIL reset_state: got disp=%h st=%0d op=%0d ovf=%b rv=%b want all zero",
                  display_value, state, op_code, overflow, result_valid);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_hex_add();
      dec_mode = 1'b0;
      press(5'h1); press(5'h2); press(KEY_ADD); press(5'h3); press(KEY_EXE);
      n_total++;
      if (display_value !== 16'h0015) $display("FAIL hex_add_disp: got %h want 0015", display_value);
      else n_pass++;
      n_total++;
      if (result_valid !== 1'b1 || overflow !== 1'b0 || state !== S_RES)
         $display("FAIL hex_add_flags: got rv=%b ovf=%b st=%0d want rv=1 ovf=0 st=3", result_valid, overflow, state);
      else n_pass++;
      idle();
      n_total++;
      if (result_valid !== 1'b0) $display("FAIL hex_add_pulse: got rv=%b want 0 on the following cycle", result_valid);
      else n_pass++;
   endtask

   task automatic test_dec_mul();
      press(KEY_CLR);
      dec_mode = 1'b1;
      press(5'h9); press(5'h9); press(KEY_MUL); press(5'h1); press(5'h1); press(KEY_EXE);
      n_total++;
      if (display_value !== 16'h0441 || overflow !== 1'b0)
         $display("FAIL dec_mul_1089: got disp=%h ovf=%b want 0441 ovf=0", display_value, overflow);
      else n_pass++;
      for (int i = 0; i < 4; i++) press(5'h9);
      press(KEY_MUL);
      for (int i = 0; i < 4; i++) press(5'h9);
      press(KEY_EXE);
      n_total++;
      if (overflow !== 1'b1 || display_value !== 16'(m_res))
         $display("FAIL dec_mul_ovf: got disp=%h ovf=%b want %h ovf=1", display_value, overflow, 16'(m_res));
      else n_pass++;
   endtask

   task automatic test_hex_sub_limits();
      dec_mode = 1'b0;
      press(KEY_CLR);
      press(5'h2); press(KEY_SUB); press(5'h5); press(KEY_EXE);
      n_total++;
      if (display_value !== 16'hFFFD || overflow !== 1'b1)
         $display("FAIL hex_sub: got disp=%h ovf=%b want fffd ovf=1", display_value, overflow);
      else n_pass++;
      press(5'h1); press(5'h2); press(5'h3); press(5'h4); press(5'h5);
      n_total++;
      if (display_value !== 16'h1234 || state !== S_A || overflow !== 1'b0)
         $display("FAIL hex_digit_limit: got disp=%h st=%0d ovf=%b want 1234 st=0 ovf=0", display_value, state, overflow);
      else n_pass++;
      press(KEY_CLR);
      dec_mode = 1'b1;
      press(5'h0A);
      n_total++;
      if (display_value !== 16'h0) $display("FAIL dec_digit_a: got %h want 0000", display_value);
      else n_pass++;
      press(5'h5);
      n_total++;
      if (display_value !== 16'h0005) $display("FAIL dec_digit_5: got %h want 0005", display_value);
      else n_pass++;
   endtask

   task automatic test_chain_ce();
      dec_mode = 1'b0;
      press(KEY_CLR);
      press(5'h4); press(KEY_ADD); press(5'h2); press(KEY_MUL);
      n_total++;
      if (display_value !== 16'h0006 || state !== S_OP || op_code !== OP_MUL || result_valid !== 1'b1)
         $display("FAIL chain: got disp=%h st=%0d op=%0d rv=%b want 0006 st=1 op=3 rv=1",
                  display_value, state, op_code, result_valid);
      else n_pass++;
      press(5'h7); press(KEY_CE);
      n_total++;
      if (state !== S_OP || display_value !== 16'h0006)
         $display("FAIL ce_in_b: got st=%0d disp=%h want st=1 disp=0006", state, display_value);
      else n_pass++;
      press(5'h3); press(KEY_EXE);
      n_total++;
      if (display_value !== 16'h0012) $display("FAIL chain_exe: got %h want 0012", display_value);
      else n_pass++;
   endtask

   task automatic test_clr_reset();
      press(KEY_CLR);
      press(5'h1); press(KEY_ADD); press(5'h2);
      press(KEY_CLR);
      n_total++;
      if (display_value !== 16'h0 || state !== S_A || op_code !== OP_NONE || overflow !== 1'b0)
         $display("FAIL clr_in_b: got disp=%h st=%0d op=%0d ovf=%b want zeros", display_value, state, op_code, overflow);
      else n_pass++;
      press(5'h9); press(5'h8);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      n_total++;
      if (display_value !== 16'h0 || state !== S_A || op_code !== OP_NONE)
         $display("FAIL async_reset: got disp=%h st=%0d op=%0d want zeros before any edge", display_value, state, op_code);
      else n_pass++;
      @(negedge clk);
      val = 5'h7;
      select = 1'b1;
      @(posedge clk);
      #1;
      select = 1'b0;
      val = KEY_NONE;
      n_total++;
      if (display_value !== 16'h0 || state !== S_A)
         $display("FAIL select_in_reset: got disp=%h st=%0d want 0000 st=0", display_value, state);
      else n_pass++;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_pulse_hygiene();
      dec_mode = 1'b0;
      press(5'h3);
      @(negedge clk);
      val = 5'h5;
      for (int i = 0; i < 10; i++) begin
         idle();
         n_total++;
         if (display_value !== 16'(m_disp()) || result_valid !== 1'b0)
            $display("FAIL hold_no_select: cycle %0d got disp=%h rv=%b want %h rv=0", i, display_value, result_valid, 16'(m_disp()));
         else n_pass++;
      end
      val = KEY_NONE;
      press(KEY_EXE);
      n_total++;
      if (result_valid !== 1'b0 || state !== S_A) $display("FAIL exe_in_a: got rv=%b st=%0d want rv=0 st=0", result_valid, state);
      else n_pass++;
      press(KEY_OR); press(KEY_EXE);
      n_total++;
      if (result_valid !== 1'b0 || state !== S_OP) $display("FAIL exe_in_op: got rv=%b st=%0d want rv=0 st=1", result_valid, state);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [4:0] k;
      int r;
      press(KEY_CLR);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) dec_mode = ~dec_mode;
         r = $urandom_range(0, 99);
         if (r < 55)      k = 5'($urandom_range(0, 15));
         else if (r < 78) k = 5'($urandom_range(16, 18));
         else if (r < 82) k = 5'($urandom_range(20, 21));
         else if (r < 90) k = KEY_EXE;
         else if (r < 95) k = KEY_CE;
         else if (r < 97) k = KEY_CLR;
         else             k = 5'($urandom_range(24, 31));
         press(k);
         n_total++;
         if (display_value !== 16'(m_disp()) || state !== m_st || op_code !== m_op ||
             overflow !== m_ovf || result_valid !== m_rv)
            $display("FAIL random_key %0d (key %h dec %b): got disp=%h st=%0d op=%0d ovf=%b rv=%b want disp=%h st=%0d op=%0d ovf=%b rv=%b",
                     i, k, dec_mode, display_value, state, op_code, overflow, result_valid,
                     16'(m_disp()), m_st, m_op, m_ovf, m_rv);
         else n_pass++;
      end
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      test_reset();
      test_hex_add();
      test_dec_mul();
      test_hex_sub_limits();
      test_chain_ce();
      test_clr_reset();
      test_pulse_hygiene();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/calc_entry_fsm.md
Name: calc_entry_fsm

Overview:
- Consumes the cursor stage's 5-bit key code `val` together with a one-cycle `select` pulse from the button pulse stage.
- Assembles operand A, the operator and operand B, evaluates the operation on EXE, and drives the value shown on the display.
- Supports HEX and DEC entry. `dec_mode` is the same signal that drives the cursor's `restriction` input.

Parameters:
- W, 16: operand/result width in bits.
- HEX_DIGITS, 4: maximum hex digits per operand; must equal W/4.
- DEC_DIGITS, 4: maximum decimal digits per operand; DEC_MAX = 10^DEC_DIGITS - 1 = 9999.

Ports:
- clk  in  1  system clock, same clock as the VGA/cursor domain.
- rst  in  1  asynchronous, active-low reset.
- select  in  1  one-cycle pulse that applies the key currently held in `val`.
- val  in  5  key code: 0x00-0x0F digit, 0x10 ADD, 0x11 MUL, 0x12 AND, 0x13 EXE, 0x14 SUB, 0x15 OR, 0x16 CE, 0x17 CLR, 0x1F none.
- dec_mode  in  1  1 = decimal entry and arithmetic limits; 0 = hex.
- display_value  out  W  value to display.
- op_code  out  3  stored operator (NONE/ADD/SUB/MUL/AND/OR).
- state  out  2  current FSM state, for the display overlay.
- overflow  out  1  sticky error flag for the last computation.
- result_valid  out  1  one-cycle pulse when a computation completes.

Behaviour:
- Reset (rst=0, asynchronous): state=S_A; A=B=result=0; digit count=0; op_code=NONE; overflow=0; result_valid=0; display_value=0. Reset wins over a simultaneous `select`.
- All registers update on posedge clk only when select=1. Latency from select to the visible output is 1 cycle.
- Ignored keys: `select` with val=0x1F or any undefined code causes no change.
- Digit validity: in DEC mode a digit >9 is ignored.
- Digit limit: a digit is ignored once count = HEX_DIGITS (hex) or DEC_DIGITS (dec).
- Digit append: hex operand = {operand[W-5:0], d}; dec operand = operand*10 + d. Count increments by 1.
- dec_mode changing mid-entry: no conversion; the new mode applies from the next key.
- States: S_A (entering A), S_OP (operator held, B empty), S_B (entering B), S_RES (result shown).
- S_A: digit appends to A. Operator stores op and goes to S_OP (A may be 0). EXE is ignored. CE clears A and count.
- S_OP: digit sets B=d, count=1, goes to S_B. Operator replaces op. EXE is ignored. CE: no change.
- S_B: digit appends to B. EXE computes, sets A=result, goes to S_RES and pulses result_valid. Operator chains: computes, sets A=result, stores the new op, goes to S_OP and pulses result_valid. CE sets B=0, count=0 and returns to S_OP.
- S_RES: digit starts a new A (A=d, count=1, overflow cleared) and goes to S_A. Operator stores op and goes to S_OP, keeping A=result. CE acts as CLR.
- CLR, from any state, behaves identically to reset.
- Arithmetic is modulo 2^W:
  - ADD: overflow on carry-out.
  - SUB (A-B): wraps; overflow when B>A.
  - MUL: low W bits; overflow when the upper W bits ≠ 0.
  - AND/OR: bitwise, never overflow.
  - DEC mode additionally sets overflow when the result > DEC_MAX.
- The overflow flag is overwritten by each computation.
- display_value per state: S_A and S_OP show A; S_B shows B; S_RES shows result.

Decomposition:
- Package calc_pkg holds:
  - localparams for every val code;
  - an op_t enum (NONE, ADD, SUB, MUL, AND, OR), 3 bits;
  - an entry_state_t enum (S_A, S_OP, S_B, S_RES), 2 bits.
- Sub-module calc_alu: combinational; inputs a, b, op, dec_mode; outputs result[W-1:0] and ovf.
- The FSM and the digit-append datapath stay in calc_entry_fsm.

Test Plan:
- Hex ADD: hex keys 1,2,ADD,3,EXE -> display 0x0015, result_valid pulses once, overflow=0, state=S_RES.
- DEC MUL: dec keys 9,9,MUL,1,1,EXE -> display 1089 (0x0441). Then keys 9,9,9,9,MUL,9,9,9,9,EXE -> overflow=1.
- Hex SUB with limits: hex keys 2,SUB,5,EXE -> 0xFFFD, overflow=1. Hex keys 1,2,3,4,5 -> A=0x1234, fifth digit ignored. DEC mode key 0x0A -> ignored.
- Chaining and CE: keys 4,ADD,2,MUL -> display 6, state S_OP. Then 7, CE, 3, EXE -> 18 (0x12).
- CLR and reset: CLR in S_B -> all zero, state S_A. rst=0 asserted asynchronously mid-entry (no clock edge needed) -> outputs zero immediately. A select coincident with reset has no effect.
- Pulse hygiene: val held at a digit with select low for 10 cycles -> no change. EXE in S_A or S_OP -> no result_valid pulse.
